cr16_controller: RTL and testbench
==================================

# cr16_controller

Multi-cycle sequencing FSM for the CR16 datapath. Fetches 16-bit instructions over a request/valid memory handshake and decodes them. Drives the datapath's register-enable, port-select, opcode, immediate and ALU-enable inputs for exactly one execute cycle per instruction. Sits between instruction memory and `cr16_datapath`, and owns the program counter.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `NOWB_OPCODE`, 4'hB, ALU opcode whose result is not written back (compare); flags still update.

Ports:
- `I_CLK`  in  1  sole clock, rising edge.
- `I_NRESET`  in  1  reset, synchronous, active-low.
- `I_RUN`  in  1  run enable; low holds the controller in FETCH without issuing requests.
- `O_MEM_REQ`  out  1  fetch request.
- `O_MEM_ADDR`  out  16  fetch address; equals PC.
- `I_MEM_VALID`  in  1  instruction word valid.
- `I_MEM_DATA`  in  16  instruction word.
- `O_REG_ENABLE`  out  16  one-hot write enable to the register file.
- `O_OPCODE`  out  4  ALU opcode.
- `O_ALU_ENABLE`  out  1  ALU/flags enable.
- `O_READ_PORT_A_SEL`  out  4  port A register select.
- `O_READ_PORT_B_SEL`  out  4  port B register select.
- `O_IMMEDIATE`  out  16  sign-extended immediate.
- `O_IMM_SEL`  out  1  1 = immediate onto bus B.
- `O_PC`  out  16  current PC.
- `O_HALTED`  out  1  high in HALT state.

## Operation
- The instruction register IR has these fields: [15:12] major, [11:8] Rdest, [7:4] ext/imm-high, [3:0] Rsrc/imm-low.
- Decode by the major field:
  - major = 4'h0 (RR): opcode = IR[7:4]; A = Rdest; B = Rsrc; IMM_SEL = 0.
  - major 4'h1..4'hE (immediate): opcode = major; A = Rdest; IMMEDIATE = {{8{IR[7]}}, IR[7:0]}; IMM_SEL = 1; B sel = 0.
  - major = 4'hF: HALT.
- In EXECUTE, REG_ENABLE = 1 << Rdest, except when opcode == `NOWB_OPCODE`, where REG_ENABLE = 0.
- States:
  - FETCH: O_MEM_REQ = I_RUN, combinational from state. On REQ && I_MEM_VALID, latch IR ← I_MEM_DATA, PC ← PC+1 (16-bit wrap, FFFF→0000), go to DECODE. Otherwise stay.
  - DECODE: one cycle. Register all control outputs from IR. HALT major → HALT; else → EXECUTE.
  - EXECUTE: one cycle. Control outputs and ALU_ENABLE = 1 are valid; the datapath writes Rdest and flags at the closing edge. Then clear all control outputs and go to FETCH.
  - HALT: all control outputs 0; O_HALTED = 1. Only reset exits.
- I_MEM_VALID is ignored whenever O_MEM_REQ is low, including in non-FETCH states and while I_RUN is low.
- I_RUN only gates requests in FETCH. An instruction already past FETCH completes regardless of I_RUN.

## Timing
- Reset values:
  - State FETCH, PC = `RESET_PC`, IR = 0.
  - O_REG_ENABLE, O_OPCODE, O_ALU_ENABLE, both SELs, O_IMMEDIATE, O_IMM_SEL, O_HALTED all 0.
  - O_MEM_REQ = I_RUN.
- Reset mid-instruction: the next edge with I_NRESET low aborts the instruction. No register write occurs in the following cycle, and PC reloads.
- Throughput: 3 cycles per instruction with zero-wait memory (VALID in the REQ cycle). Each memory wait cycle adds 1.
- Control outputs are registered. They are nonzero only during the single EXECUTE cycle, so there are no glitches on REG_ENABLE.
- O_MEM_ADDR = O_PC at all times. PC increments at the fetch-accept edge, so during DECODE/EXECUTE O_PC points to the next instruction.

## Structure
- Package `cr16_pkg`:
  - State enum {FETCH, DECODE, EXECUTE, HALT}.
  - Field position constants.
  - `MAJOR_RR = 4'h0`, `MAJOR_HALT = 4'hF`.
- Sub-module `cr16_decoder`: purely combinational IR → control bundle, including the one-hot Rdest and sign extension. The controller registers its outputs on the DECODE→EXECUTE edge.
- Remaining RTL: the FSM, the PC, the IR and the output registers.

## Test plan
- Reset then I_RUN=1 with zero-wait memory; mem[0]=16'h0152 (RR, Rdest=1, op=5, Rsrc=2) → REQ at addr 0; EXECUTE on cycle 3 with REG_ENABLE=16'h0002, OPCODE=5, A=1, B=2, IMM_SEL=0, ALU_ENABLE=1; next REQ at addr 1.
- Instruction 16'h53F0 (major 5, Rdest=3, imm 8'hF0) → IMMEDIATE=16'hFFF0, IMM_SEL=1, OPCODE=5, REG_ENABLE=16'h0008.
- RR with ext = 4'hB (`NOWB_OPCODE`) → REG_ENABLE=0 and ALU_ENABLE=1 during EXECUTE.
- I_MEM_VALID delayed 4 cycles; VALID pulse injected during EXECUTE → REQ held steady, instruction latched only on the in-REQ VALID; the stray pulse does not change IR or PC.
- Fetch 16'hF000 → O_HALTED=1 and REQ=0 forever; I_NRESET low for one edge → PC=`RESET_PC`, HALTED=0.
- PC=16'hFFFF fetch → PC wraps to 0000. Reset asserted during EXECUTE → REG_ENABLE=0 in the following cycle.

Source files
------------

// File: rtl/cr16_pkg.sv
// Shared types and constants for the CR16 sequencing controller.
// Holds the FSM state encoding, the instruction field layout and the decoded control bundle.
package cr16_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2,
    HALT    = 2'd3
  } state_t;

  localparam int MAJOR_MSB = 15;
  localparam int MAJOR_LSB = 12;
  localparam int RDEST_MSB = 11;
  localparam int RDEST_LSB = 8;
  localparam int EXT_MSB   = 7;
  localparam int EXT_LSB   = 4;
  localparam int RSRC_MSB  = 3;
  localparam int RSRC_LSB  = 0;

  localparam logic [3:0] MAJOR_RR   = 4'h0;
  localparam logic [3:0] MAJOR_HALT = 4'hF;

  typedef struct packed {
    logic [15:0] reg_enable;
    logic [3:0]  opcode;
    logic [3:0]  sel_a;
    logic [3:0]  sel_b;
    logic [15:0] immediate;
    logic        imm_sel;
    logic        halt;
  } ctrl_t;

  function automatic logic [15:0] sign_extend8(input logic [7:0] value);
    return {{8{value[7]}}, value};
  endfunction

  function automatic logic [15:0] onehot16(input logic [3:0] index);
    return 16'h0001 << index;
  endfunction

endpackage

// File: rtl/cr16_decoder.sv
// Combinational instruction decoder: maps the instruction register onto the
// datapath control bundle, including the one-hot write enable and immediate sign extension.
module cr16_decoder
  import cr16_pkg::*;
#(
  parameter logic [3:0] NOWB_OPCODE = 4'hB
) (
  input  logic [15:0] ir,
  output ctrl_t       ctrl
);

  logic [3:0] major_s;
  logic [3:0] rdest_s;
  logic [3:0] ext_s;
  logic [3:0] rsrc_s;

  assign major_s = ir[MAJOR_MSB:MAJOR_LSB];
  assign rdest_s = ir[RDEST_MSB:RDEST_LSB];
  assign ext_s   = ir[EXT_MSB:EXT_LSB];
  assign rsrc_s  = ir[RSRC_MSB:RSRC_LSB];

  // Field decode by major opcode class, then write-enable suppression for compare.
  always_comb begin
    ctrl = '0;
    case (major_s)
      MAJOR_RR: begin
        ctrl.opcode  = ext_s;
        ctrl.sel_a   = rdest_s;
        ctrl.sel_b   = rsrc_s;
        ctrl.imm_sel = 1'b0;
      end
      MAJOR_HALT: begin
        ctrl.halt = 1'b1;
      end
      default: begin
        ctrl.opcode    = major_s;
        ctrl.sel_a     = rdest_s;
        ctrl.sel_b     = 4'h0;
        ctrl.immediate = sign_extend8(ir[EXT_MSB:RSRC_LSB]);
        ctrl.imm_sel   = 1'b1;
      end
    endcase
    // Compare results are discarded; only the flags see them.
    if (!ctrl.halt && (ctrl.opcode != NOWB_OPCODE)) begin
      ctrl.reg_enable = onehot16(rdest_s);
    end else begin
      ctrl.reg_enable = 16'h0000;
    end
  end

endmodule

// File: rtl/cr16_controller.sv
// CR16 sequencing FSM: fetches instructions over a req/valid handshake, owns the PC and IR,
// and presents registered datapath controls for exactly one EXECUTE cycle per instruction.
module cr16_controller
  import cr16_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  NOWB_OPCODE = 4'hB
) (
  input  logic        I_CLK,
  input  logic        I_NRESET,
  input  logic        I_RUN,
  output logic        O_MEM_REQ,
  output logic [15:0] O_MEM_ADDR,
  input  logic        I_MEM_VALID,
  input  logic [15:0] I_MEM_DATA,
  output logic [15:0] O_REG_ENABLE,
  output logic [3:0]  O_OPCODE,
  output logic        O_ALU_ENABLE,
  output logic [3:0]  O_READ_PORT_A_SEL,
  output logic [3:0]  O_READ_PORT_B_SEL,
  output logic [15:0] O_IMMEDIATE,
  output logic        O_IMM_SEL,
  output logic [15:0] O_PC,
  output logic        O_HALTED
);

  state_t      state_r;
  state_t      state_nx_s;
  logic [15:0] pc_r;
  logic [15:0] ir_r;
  ctrl_t       dec_s;
  logic        accept_s;

  logic [15:0] reg_enable_r;
  logic [3:0]  opcode_r;
  logic        alu_enable_r;
  logic [3:0]  sel_a_r;
  logic [3:0]  sel_b_r;
  logic [15:0] immediate_r;
  logic        imm_sel_r;
  logic        halted_r;

  cr16_decoder #(
    .NOWB_OPCODE(NOWB_OPCODE)
  ) u_decoder (
    .ir  (ir_r),
    .ctrl(dec_s)
  );

  assign O_MEM_REQ = (state_r == FETCH) && I_RUN;
  assign accept_s  = O_MEM_REQ && I_MEM_VALID;

  // FSM state register.
  always_ff @(posedge I_CLK) begin
    if (!I_NRESET) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      FETCH: begin
        if (accept_s) begin
          state_nx_s = DECODE;
        end else begin
          state_nx_s = FETCH;
        end
      end
      DECODE: begin
        if (dec_s.halt) begin
          state_nx_s = HALT;
        end else begin
          state_nx_s = EXECUTE;
        end
      end
      EXECUTE: state_nx_s = FETCH;
      HALT:    state_nx_s = HALT;
      default: state_nx_s = FETCH;
    endcase
  end

  // Program counter and instruction register, updated only on an accepted fetch.
  always_ff @(posedge I_CLK) begin
    if (!I_NRESET) begin
      pc_r <= RESET_PC;
      ir_r <= 16'h0000;
    end else if (accept_s) begin
      pc_r <= pc_r + 16'h0001;
      ir_r <= I_MEM_DATA;
    end else begin
      pc_r <= pc_r;
      ir_r <= ir_r;
    end
  end

  // Control outputs load on the DECODE->EXECUTE edge and clear on every other edge.
  always_ff @(posedge I_CLK) begin
    if (!I_NRESET) begin
      reg_enable_r <= 16'h0000;
      opcode_r     <= 4'h0;
      alu_enable_r <= 1'b0;
      sel_a_r      <= 4'h0;
      sel_b_r      <= 4'h0;
      immediate_r  <= 16'h0000;
      imm_sel_r    <= 1'b0;
      halted_r     <= 1'b0;
    end else begin
      if ((state_r == DECODE) && !dec_s.halt) begin
        reg_enable_r <= dec_s.reg_enable;
        opcode_r     <= dec_s.opcode;
        alu_enable_r <= 1'b1;
        sel_a_r      <= dec_s.sel_a;
        sel_b_r      <= dec_s.sel_b;
        immediate_r  <= dec_s.immediate;
        imm_sel_r    <= dec_s.imm_sel;
      end else begin
        reg_enable_r <= 16'h0000;
        opcode_r     <= 4'h0;
        alu_enable_r <= 1'b0;
        sel_a_r      <= 4'h0;
        sel_b_r      <= 4'h0;
        immediate_r  <= 16'h0000;
        imm_sel_r    <= 1'b0;
      end
      if ((state_r == DECODE) && dec_s.halt) begin
        halted_r <= 1'b1;
      end else begin
        halted_r <= halted_r;
      end
    end
  end

  assign O_MEM_ADDR        = pc_r;
  assign O_PC              = pc_r;
  assign O_REG_ENABLE      = reg_enable_r;
  assign O_OPCODE          = opcode_r;
  assign O_ALU_ENABLE      = alu_enable_r;
  assign O_READ_PORT_A_SEL = sel_a_r;
  assign O_READ_PORT_B_SEL = sel_b_r;
  assign O_IMMEDIATE       = immediate_r;
  assign O_IMM_SEL         = imm_sel_r;
  assign O_HALTED          = halted_r;

endmodule

// File: tb/tb_cr16_controller.sv
// Scoreboard bench for cr16_controller: a random-latency memory feeds instructions,
// a spec-level model predicts each execute bundle and the fetch/halt timing.
module tb_cr16_controller;

  localparam logic [15:0] RESET_PC = 16'hFFFD;
  localparam int          NOWB     = 11;

  logic        I_CLK;
  logic        I_NRESET;
  logic        I_RUN;
  logic        O_MEM_REQ;
  logic [15:0] O_MEM_ADDR;
  logic        I_MEM_VALID;
  logic [15:0] I_MEM_DATA;
  logic [15:0] O_REG_ENABLE;
  logic [3:0]  O_OPCODE;
  logic        O_ALU_ENABLE;
  logic [3:0]  O_READ_PORT_A_SEL;
  logic [3:0]  O_READ_PORT_B_SEL;
  logic [15:0] O_IMMEDIATE;
  logic        O_IMM_SEL;
  logic [15:0] O_PC;
  logic        O_HALTED;

  cr16_controller #(
    .RESET_PC   (RESET_PC),
    .NOWB_OPCODE(4'hB)
  ) dut (
    .I_CLK            (I_CLK),
    .I_NRESET         (I_NRESET),
    .I_RUN            (I_RUN),
    .O_MEM_REQ        (O_MEM_REQ),
    .O_MEM_ADDR       (O_MEM_ADDR),
    .I_MEM_VALID      (I_MEM_VALID),
    .I_MEM_DATA       (I_MEM_DATA),
    .O_REG_ENABLE     (O_REG_ENABLE),
    .O_OPCODE         (O_OPCODE),
    .O_ALU_ENABLE     (O_ALU_ENABLE),
    .O_READ_PORT_A_SEL(O_READ_PORT_A_SEL),
    .O_READ_PORT_B_SEL(O_READ_PORT_B_SEL),
    .O_IMMEDIATE      (O_IMMEDIATE),
    .O_IMM_SEL        (O_IMM_SEL),
    .O_PC             (O_PC),
    .O_HALTED         (O_HALTED)
  );

  typedef struct {
    int          due;
    logic [45:0] ctrl;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          next_fetch_cyc = 0;
  int          halt_cyc = -1;
  int          wait_cnt = 0;
  int          fetch_idx = 0;
  int          run_mode = 0;
  bit          mon_en = 1'b0;
  bit          mem_en = 1'b0;
  logic [15:0] model_pc = RESET_PC;
  logic [15:0] mem [0:65535];
  exp_t        q[$];

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [45:0] ctrl_now();
    return {O_REG_ENABLE, O_OPCODE, O_ALU_ENABLE, O_READ_PORT_A_SEL,
            O_READ_PORT_B_SEL, O_IMMEDIATE, O_IMM_SEL};
  endfunction

  // Expected execute bundle written straight from the instruction-format rules.
  function automatic logic [45:0] exp_ctrl(input logic [15:0] instr);
    int v, major, rd, ext, rs, op, a, b, imm, isel, wen;
    v     = int'(instr);
    major = v / 4096;
    rd    = (v / 256) % 16;
    ext   = (v / 16) % 16;
    rs    = v % 16;
    if (major == 0) begin
      op = ext; a = rd; b = rs; imm = 0; isel = 0;
    end else begin
      op = major; a = rd; b = 0; isel = 1;
      imm = v % 256;
      if (imm >= 128) imm = imm + 65280;
    end
    wen = (op == NOWB) ? 0 : (1 << rd);
    return {wen[15:0], op[3:0], 1'b1, a[3:0], b[3:0], imm[15:0], isel[0]};
  endfunction

  function automatic logic [15:0] rand_instr();
    logic [15:0] r;
    r = 16'($urandom);
    r[15:12] = 4'($urandom_range(0, 14));
    return r;
  endfunction

  function automatic int next_wait();
    if (fetch_idx < 3) return 0;
    if (fetch_idx == 3) return 4;
    return $urandom_range(0, 3);
  endfunction

  task automatic model_reset();
    model_pc       = RESET_PC;
    q.delete();
    next_fetch_cyc = cyc;
    halt_cyc       = -1;
    wait_cnt       = 0;
  endtask

  // Memory and run-enable driver: random wait states, stray VALID pulses when not requested.
  initial begin
    I_RUN = 1'b0; I_MEM_VALID = 1'b0; I_MEM_DATA = 16'h0000;
    forever begin
      @(posedge I_CLK);
      #1;
      case (run_mode)
        0:       I_RUN = 1'b0;
        1:       I_RUN = 1'b1;
        default: I_RUN = ($urandom_range(0, 9) != 0);
      endcase
      #1;
      if (mem_en && O_MEM_REQ) begin
        if (wait_cnt == 0) begin
          I_MEM_VALID = 1'b1;
          I_MEM_DATA  = mem[O_MEM_ADDR];
          fetch_idx++;
          wait_cnt = next_wait();
        end else begin
          I_MEM_VALID = 1'b0;
          I_MEM_DATA  = 16'($urandom);
          wait_cnt--;
        end
      end else begin
        I_MEM_VALID = mem_en && ($urandom_range(0, 2) == 0);
        I_MEM_DATA  = 16'($urandom);
      end
    end
  end

  // Monitor: compares the DUT against the model every cycle and scores accepted fetches.
  always @(negedge I_CLK) begin
    logic exp_req;
    exp_t e;
    cyc = cyc + 1;
    if (mon_en) begin
      exp_req = I_RUN && (cyc >= next_fetch_cyc);
      chk("mem_req", 64'(O_MEM_REQ), 64'(exp_req));
      chk("pc", 64'(O_PC), 64'(model_pc));
      chk("mem_addr", 64'(O_MEM_ADDR), 64'(model_pc));
      chk("halted", 64'(O_HALTED), 64'((halt_cyc >= 0) && (cyc >= halt_cyc)));
      if ((q.size() > 0) && (q[0].due == cyc)) begin
        e = q.pop_front();
        chk("exec_ctrl", 64'(ctrl_now()), 64'(e.ctrl));
      end else begin
        chk("idle_ctrl", 64'(ctrl_now()), 64'h0);
      end
      if (exp_req && I_MEM_VALID) begin
        model_pc = model_pc + 16'h0001;
        if (I_MEM_DATA[15:12] == 4'hF) begin
          halt_cyc       = cyc + 2;
          next_fetch_cyc = 32'h7FFFFFFF;
        end else begin
          e.due  = cyc + 2;
          e.ctrl = exp_ctrl(I_MEM_DATA);
          q.push_back(e);
          next_fetch_cyc = cyc + 3;
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_pc"}, 64'(O_PC), 64'(RESET_PC));
    chk({tag, "_addr"}, 64'(O_MEM_ADDR), 64'(RESET_PC));
    chk({tag, "_ctrl"}, 64'(ctrl_now()), 64'h0);
    chk({tag, "_halted"}, 64'(O_HALTED), 64'h0);
    chk({tag, "_req"}, 64'(O_MEM_REQ), 64'(I_RUN));
  endtask

  initial begin
    logic [15:0] a;
    bit          seen;
    for (int i = 0; i < 65536; i++) mem[i] = rand_instr();
    a = RESET_PC;
    mem[a] = 16'h0152; a = a + 16'h0001;
    mem[a] = 16'h53F0; a = a + 16'h0001;
    mem[a] = 16'h01B2; a = a + 16'h0001;
    mem[a] = 16'h7A05;
    a = RESET_PC + 16'd40;
    mem[a] = 16'hF000;

    I_NRESET = 1'b0;
    run_mode = 0;
    @(negedge I_CLK); #1;
    check_reset_state("reset_run0");
    run_mode = 1;
    @(negedge I_CLK); #1;
    check_reset_state("reset_run1");

    I_NRESET = 1'b1;
    model_reset();
    mem_en = 1'b1;
    mon_en = 1'b1;
    repeat (30) @(negedge I_CLK);
    #1;
    run_mode = 2;

    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge I_CLK); #1;
      seen = O_HALTED;
    end
    chk("halt_reached", 64'(seen), 64'h1);
    repeat (10) @(negedge I_CLK);
    #1;

    mon_en = 1'b0; mem_en = 1'b0; I_NRESET = 1'b0;
    @(negedge I_CLK); #1;
    check_reset_state("halt_exit");
    I_NRESET = 1'b1;
    model_reset();
    mem_en = 1'b1; mon_en = 1'b1;

    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge I_CLK); #1;
      seen = O_ALU_ENABLE;
    end
    chk("exec_reached", 64'(seen), 64'h1);
    mon_en = 1'b0; mem_en = 1'b0; I_NRESET = 1'b0;
    @(negedge I_CLK); #1;
    check_reset_state("abort");
    I_NRESET = 1'b1;
    model_reset();
    mem_en = 1'b1; mon_en = 1'b1;
    repeat (60) @(negedge I_CLK);
    #1;
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
